mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Parametrised load/store execution unit in the MEM stage.
- Takes a decoded memory request: read/write, size, sign, address and store data.
- Drives a word-wide data bus with byte-lane selects and waits for the bus acknowledge, timing out if none arrives.
- Returns aligned, sign- or zero-extended load data. Stalls the pipeline while a bus transaction is outstanding.

Parameters:
- DATA_WIDTH, 32, bus/register data width; power of two, at least 16.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT, 15, bus cycles without `bus_ack` before the access is abandoned with an error; minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_read  in  1  load.
- req_write  in  1  store; wins if both read and write are set.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_sign  in  1  sign-extend load data.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- bus_en  out  1  bus access active.
- bus_we  out  1  bus write.
- bus_sel  out  DATA_WIDTH/8  byte-lane enables.
- bus_addr  out  ADDR_WIDTH  address with the low log2(DATA_WIDTH/8) bits forced to 0.
- bus_wdata  out  DATA_WIDTH  lane-shifted store data.
- bus_rdata  in  DATA_WIDTH  bus read data.
- bus_ack  in  1  transfer complete.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, unsupported size, or timeout; qualified by resp_valid.
- stall  out  1  req_valid && !req_ready.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Definitions: BYTES = DATA_WIDTH/8; OFF = req_addr[log2(BYTES)-1:0]; NB = 1<<req_size.
- States: IDLE, BUS, RESP.
- Reset: state IDLE, counter 0, all registered outputs 0, `req_ready` = 0 while rst is high.
- req_ready:
  - Equals 1 only in IDLE when rst is low.
  - It is 0 in BUS and RESP, so back-to-back requests are accepted at most every 2 cycles.
- Acceptance: happens on req_valid && req_ready. The request is registered.
- Error at accept: any of the following goes to RESP with resp_err=1 and no bus activity (bus_en stays 0):
  - NB > BYTES (unsupported size),
  - OFF not a multiple of NB (misaligned),
  - neither read nor write set.
- Legal access at accept: enter BUS next cycle with
  - bus_en=1,
  - bus_we=req_write,
  - bus_sel = ((1<<NB)-1) << OFF, little-endian,
  - bus_wdata = low NB bytes of req_wdata shifted left by OFF*8, other bytes 0,
  - bus_addr = req_addr with the offset bits cleared.
- BUS state:
  - All bus outputs are held stable until bus_ack.
  - The counter increments each BUS cycle without ack.
- bus_ack in BUS:
  - Next cycle: bus_en=0, state RESP, resp_valid=1.
  - For a read, resp_rdata = (bus_rdata >> OFF*8) masked to NB bytes.
  - That value is sign-extended from bit NB*8-1 if req_sign, else zero-extended.
  - When NB = BYTES, no extension is applied.
- Timeout: if the counter reaches TIMEOUT with no ack, next cycle bus_en=0, state RESP, resp_err=1, resp_rdata=0.
- bus_ack in the same cycle the counter hits TIMEOUT: the ack wins; no error.
- RESP state:
  - Lasts exactly 1 cycle. resp_valid=1.
  - Then IDLE, with resp_valid=0, resp_err=0, counter 0.
  - resp_rdata holds its value until the next response.
- Latency: accept at cycle T, ack at T+1, resp_valid at T+2. Error at accept gives resp_valid at T+1.
- bus_ack outside BUS: ignored.
- rst mid-operation: the access is abandoned. The next cycle all outputs are 0 and no response is issued.
- Request inputs are not sampled outside the accept cycle.

Test Plan:
- Byte load, sign:
  - Stimulus: DATA_WIDTH=32; read, size 0, sign=1, addr 0x1003; ack at first BUS cycle with bus_rdata 0x80_12_34_56.
  - Required: bus_sel=4'b1000, bus_addr=0x1000; resp_valid at T+2 with resp_rdata=0xFFFFFF80.
  - Repeat with sign=0: resp_rdata=0x00000080.
- Half store:
  - Stimulus: write, size 1, addr 0x2002, wdata 0xDEADBEEF.
  - Required: bus_we=1, bus_sel=4'b1100, bus_wdata=0xBEEF0000; resp_rdata=0, resp_err=0.
- Misaligned word:
  - Stimulus: read, size 2, addr 0x0001.
  - Required: bus_en never asserted; resp_valid=1 and resp_err=1 at T+1; req_ready back to 1 at T+2.
- Wait states and timeout, TIMEOUT=3:
  - With ack after 2 wait cycles: bus outputs stay stable throughout and the response is normal.
  - With no ack: resp_err=1 after 3 BUS cycles and bus_en drops; size 3 on a 32-bit bus gives resp_err=1 at T+1.
- Stall/handshake:
  - Stimulus: req_valid held high across two requests.
  - Required: stall=1 during BUS and RESP; second request accepted only in IDLE; ack arriving in IDLE produces no resp_valid.
- Reset mid-access:
  - Stimulus: assert rst during BUS.
  - Required: next cycle bus_en=0, resp_valid=0, req_ready=0; after release req_ready=1 and a new access completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit.
//   Accepts one decoded memory request at a time (req_*). It drives a
//   word-wide bus with byte-lane selects (bus_*), waits up to TIMEOUT bus
//   cycles for bus_ack, and returns one resp_valid pulse carrying the
//   extended load data (resp_rdata) or an error (resp_err).
//   req_ready is high only in IDLE. stall = req_valid && !req_ready.
// mem_access_lane: one byte lane of the unit.
//   It computes this lane's store select and store byte from the request at
//   accept time. It also computes this lane's load result byte from the
//   registered request and bus_rdata.

module mem_access_lane #(
  parameter int LANE  = 0,
  parameter int BYTES = 4,
  parameter int LG    = 2
) (
  input  logic [LG-1:0]        w_off,
  input  logic [1:0]           w_size,
  input  logic [BYTES*8-1:0]   wdata,
  input  logic [LG-1:0]        r_off,
  input  logic [1:0]           r_size,
  input  logic                 r_sign,
  input  logic                 ext_bit,
  input  logic [BYTES*8-1:0]   rdata,
  output logic                 sel,
  output logic [7:0]           wbyte,
  output logic [7:0]           rbyte
);
  always_comb begin
    int n_w, o_w, n_r, o_r;
    n_w = 1 << w_size;
    o_w = int'(w_off);
    n_r = 1 << r_size;
    o_r = int'(r_off);
    // Store side: this lane carries store byte (LANE - off) when selected.
    sel   = (LANE >= o_w) && (LANE < o_w + n_w);
    wbyte = sel ? 8'(wdata >> ((LANE - o_w) * 8)) : 8'h00;
    // Load side: low NB result bytes come from the addressed lanes; the rest
    // are filled with the extension byte.
    if (LANE < n_r) rbyte = 8'(rdata >> ((LANE + o_r) * 8));
    else            rbyte = (r_sign && ext_bit) ? 8'hFF : 8'h00;
  end
endmodule

module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_read,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_sign,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    bus_en,
  output logic                    bus_we,
  output logic [DATA_WIDTH/8-1:0] bus_sel,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  input  logic                    bus_ack,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    stall
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LG    = $clog2(BYTES);
  localparam int CW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt;
  logic [LG-1:0]          req_off, r_off;
  logic [1:0]             r_size;
  logic                   r_sign, r_write;
  logic                   accept, acc_err, misalign, timeout, ext_bit;
  logic [BYTES-1:0]       lane_sel;
  logic [BYTES-1:0][7:0]  lane_wbyte, lane_rbyte;
  logic [DATA_WIDTH-1:0]  load_data, store_data;

  assign req_off    = req_addr[LG-1:0];
  assign req_ready  = (state == IDLE) && !rst;
  assign stall      = req_valid && !req_ready;
  assign accept     = req_valid && req_ready;
  // The counter holds completed wait cycles. Reaching TIMEOUT-1 here means
  // this is the last allowed bus cycle.
  assign timeout    = (cnt == CW'(TIMEOUT - 1));
  assign load_data  = lane_rbyte;
  assign store_data = lane_wbyte;

  // Misaligned when any offset bit below log2(NB) is set.
  always_comb begin
    misalign = 1'b0;
    for (int i = 0; i < LG; i++)
      if (i < int'(req_size)) misalign = misalign | req_off[i];
    acc_err = (int'(req_size) > LG) || misalign || !(req_read || req_write);
  end

  // Sign source is the top bit of the addressed NB-byte field.
  always_comb
    ext_bit = 1'(bus_rdata >> ((int'(r_off) + (1 << r_size)) * 8 - 1));

  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    mem_access_lane #(.LANE(i), .BYTES(BYTES), .LG(LG)) u_lane (
      .w_off   (req_off),
      .w_size  (req_size),
      .wdata   (req_wdata),
      .r_off   (r_off),
      .r_size  (r_size),
      .r_sign  (r_sign),
      .ext_bit (ext_bit),
      .rdata   (bus_rdata),
      .sel     (lane_sel[i]),
      .wbyte   (lane_wbyte[i]),
      .rbyte   (lane_rbyte[i])
    );
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = acc_err ? RESP : BUS;
      BUS:     if (bus_ack || timeout) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      r_off      <= '0;
      r_size     <= '0;
      r_sign     <= 1'b0;
      r_write    <= 1'b0;
      bus_en     <= 1'b0;
      bus_we     <= 1'b0;
      bus_sel    <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          r_off   <= req_off;
          r_size  <= req_size;
          r_sign  <= req_sign;
          r_write <= req_write;
          cnt     <= '0;
          if (acc_err) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            bus_en    <= 1'b1;
            bus_we    <= req_write;
            bus_sel   <= lane_sel;
            bus_addr  <= req_addr & ~ADDR_WIDTH'(BYTES - 1);
            bus_wdata <= store_data;
          end
        end
        BUS: begin
          // An ack on the final allowed cycle still completes normally.
          if (bus_ack || timeout) begin
            bus_en     <= 1'b0;
            bus_we     <= 1'b0;
            bus_sel    <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            resp_valid <= 1'b1;
            resp_err   <= !bus_ack;
            resp_rdata <= (bus_ack && !r_write) ? load_data : '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          cnt        <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
